// File: rtl/lcd_sync_decoder.sv
// Receive-side LCD sync decoder: recovers pixel X/Y from HSYNC/VSYNC/DEN,
// measures active width/height and declares lock once the timing repeats.
//
// state   | meaning
// SEARCH  | waiting for the first VSYNC fall; the partial frame is discarded
// MEASURE | counting consecutive consistent frames toward lock
// LOCKED  | timing stable; an inconsistent frame pulses ERR and drops lock
module lcd_sync_decoder #(
  parameter int MAX_WIDTH   = 1024,
  parameter int MAX_HEIGHT  = 1024,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RST_IN,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        DEN,
  output logic        PIXEL_VALID,
  output logic [10:0] X,
  output logic [10:0] Y,
  output logic        LINE_START,
  output logic        FRAME_START,
  output logic [10:0] WIDTH,
  output logic [10:0] HEIGHT,
  output logic        LOCKED,
  output logic        ERR
);

  localparam logic [10:0] X_MAX     = 11'(MAX_WIDTH - 1);
  localparam logic [10:0] H_MAX     = 11'(MAX_HEIGHT);
  localparam logic [3:0]  LOCK_LAST = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, cnt_inc;
  logic        err_nxt;

  logic        den_q, vs_q;
  logic        den_rise, den_fall, vs_fall;
  logic [10:0] line_cnt;
  logic [10:0] first_w;
  logic        first_w_vld;
  logic        line_hs_bad, x_sat, frame_bad, h_ovf;
  logic [10:0] prev_w, prev_h;
  logic [10:0] cur_w, frame_w, frame_h;
  logic        line_bad, frame_ok;

  always_comb begin
    den_rise = DEN & ~den_q;
    den_fall = ~DEN & den_q;
    vs_fall  = ~VSYNC & vs_q;
    cur_w    = X + 11'd1;
    // A line closing on the same edge as the frame still counts toward it.
    line_bad = den_fall & (x_sat | line_hs_bad | (first_w_vld & (cur_w != first_w)));
    frame_w  = first_w_vld ? first_w : (den_fall ? cur_w : 11'd0);
    frame_h  = line_cnt;
    frame_ok = ~frame_bad & ~line_bad & ~h_ovf & (frame_h != 11'd0) &
               (frame_w == prev_w) & (frame_h == prev_h);
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      state  <= ST_SEARCH;
      cnt    <= '0;
      LOCKED <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      LOCKED <= (state_nxt == ST_LOCKED);
      ERR    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    cnt_inc   = cnt + 4'd1;
    case (state)
      ST_SEARCH: begin
        if (vs_fall) begin
          state_nxt = ST_MEASURE;
          cnt_nxt   = '0;
        end
      end
      ST_MEASURE: begin
        if (vs_fall) begin
          if (frame_ok) begin
            if (cnt_inc >= LOCK_LAST) begin
              state_nxt = ST_LOCKED;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (vs_fall && !frame_ok) begin
          state_nxt = ST_MEASURE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      den_q       <= 1'b0;
      vs_q        <= 1'b0;
      PIXEL_VALID <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      X           <= '0;
      Y           <= '0;
      WIDTH       <= '0;
      HEIGHT      <= '0;
      line_cnt    <= '0;
      first_w     <= '0;
      first_w_vld <= 1'b0;
      line_hs_bad <= 1'b0;
      x_sat       <= 1'b0;
      frame_bad   <= 1'b0;
      h_ovf       <= 1'b0;
      prev_w      <= '0;
      prev_h      <= '0;
    end else begin
      den_q       <= DEN;
      vs_q        <= VSYNC;
      PIXEL_VALID <= DEN;
      LINE_START  <= den_rise;
      FRAME_START <= vs_fall;

      if (DEN) begin
        if (den_rise) begin
          X           <= '0;
          Y           <= vs_fall ? 11'd0 : line_cnt;
          line_hs_bad <= ~HSYNC;
          x_sat       <= 1'b0;
        end else begin
          // x_sat records that the line ran past the last legal column.
          X           <= (X == X_MAX) ? X : X + 11'd1;
          x_sat       <= x_sat | (X == X_MAX);
          line_hs_bad <= line_hs_bad | ~HSYNC;
        end
      end

      if (vs_fall) begin
        line_cnt    <= den_rise ? 11'd1 : 11'd0;
        first_w_vld <= 1'b0;
        frame_bad   <= 1'b0;
        h_ovf       <= 1'b0;
        if (state != ST_SEARCH) begin
          prev_w <= frame_w;
          prev_h <= frame_h;
          if (frame_h != 11'd0) begin
            WIDTH  <= frame_w;
            HEIGHT <= frame_h;
          end
        end
      end else begin
        if (den_fall) begin
          if (!first_w_vld) begin
            first_w     <= cur_w;
            first_w_vld <= 1'b1;
          end
          if (line_bad) frame_bad <= 1'b1;
        end
        // A line beyond MAX_HEIGHT saturates the count and poisons the frame.
        if (den_rise) begin
          if (line_cnt == H_MAX) h_ovf    <= 1'b1;
          else                   line_cnt <= line_cnt + 11'd1;
        end
      end
    end
  end

endmodule
